// File: rtl/vdp_pkg.sv
// Shared definitions for the VDP CPU-side port initiator.
//   vdp_state_e   : FSM state encoding used by vdp_port_master
//   VDP_ADDR_W    : width of a VRAM address
//   VDP_WRITE_BIT : bit of the high address byte that selects write mode
//   addr_hi_byte  : builds the second address byte sent in ADDR_HI
package vdp_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StAddrLo,
    StAddrHi,
    StData,
    StGap,
    StFin
  } vdp_state_e;

  localparam int unsigned VDP_ADDR_W    = 14;
  localparam int unsigned VDP_WRITE_BIT = 6;

  function automatic logic [7:0] addr_hi_byte(input logic [VDP_ADDR_W-1:0] addr,
                                               input logic                  write);
    logic [7:0] b;
    b = {2'b00, addr[VDP_ADDR_W-1:8]};
    b[VDP_WRITE_BIT] = write;
    return b;
  endfunction

endpackage

// File: rtl/vdp_tick_spacer.sv
// Gap timer between VDP port ticks.
//   clk_i      : clock
//   rst_ni     : asynchronous active-low reset
//   tick_i     : high during a tick cycle; (re)loads the gap counter
//   gap_done_o : high in the last of the TICK_GAP idle cycles after a tick
module vdp_tick_spacer
  import vdp_pkg::*;
#(
  parameter int unsigned TICK_GAP = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  output logic gap_done_o
);

  localparam int unsigned CntW = $clog2(TICK_GAP + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (tick_i) begin
      cnt_d = CntW'(TICK_GAP);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Counter holds TICK_GAP in the first gap cycle, so 1 marks the final one.
  assign gap_done_o = (cnt_q == CntW'(1));

endmodule

// File: rtl/vdp_port_master.sv
// Initiator for the VDP CPU-side port: turns one transfer command into two
// mode=1 address writes followed by len mode=0 data ticks, each tick followed
// by TICK_GAP idle cycles.
// Optional build macro VDP_PORT_SYNC_EN: precede every command with a mode=1
// status read that clears the VDP's two-byte address latch.
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   start_i, addr_i,
//   write_i, len_i         : command strobe and its fields (taken when idle)
//   wr_data_i, wr_valid_i,
//   wr_ready_o             : write byte stream (ready is combinational)
//   rd_data_o, rd_valid_o  : read byte stream, one-cycle pulses
//   busy_o, done_o         : command in progress / one-cycle completion pulse
//   vdp_mode_o, vdp_wr_tick_o, vdp_rd_tick_o, vdp_dout_o, vdp_din_i : VDP port
module vdp_port_master
  import vdp_pkg::*;
#(
  parameter int unsigned TICK_GAP = 2,
  parameter int unsigned LEN_W    = 14
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [VDP_ADDR_W-1:0] addr_i,
  input  logic                  write_i,
  input  logic [LEN_W-1:0]      len_i,
  input  logic [7:0]            wr_data_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  output logic [7:0]            rd_data_o,
  output logic                  rd_valid_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  vdp_mode_o,
  output logic                  vdp_wr_tick_o,
  output logic                  vdp_rd_tick_o,
  output logic [7:0]            vdp_dout_o,
  input  logic [7:0]            vdp_din_i
);

  vdp_state_e            state_q, nxt_q;
  logic [VDP_ADDR_W-1:0] addr_q;
  logic                  write_q;
  logic [LEN_W-1:0]      rem_q;
  logic                  busy_q, done_q;
  logic                  mode_q, wr_tick_q, rd_tick_q;
  logic [7:0]            dout_q;
  logic                  rd_pend_q, rd_valid_q;
  logic [7:0]            rd_data_q;
  logic                  gap_done;
  logic                  enter_data;
  logic                  consume;

  vdp_tick_spacer #(
    .TICK_GAP(TICK_GAP)
  ) u_spacer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .tick_i    (wr_tick_q | rd_tick_q),
    .gap_done_o(gap_done)
  );

  assign enter_data = (state_q == StGap) && gap_done && (nxt_q == StData);

  // A write byte is taken either in the last gap cycle (so back-to-back data
  // ticks keep exact spacing) or while stalled in DATA with no tick pending.
  always_comb begin
    consume = 1'b0;
    if (write_q && wr_valid_i) begin
      if (enter_data || ((state_q == StData) && !wr_tick_q)) begin
        consume = 1'b1;
      end
    end
  end

  assign wr_ready_o = consume;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      nxt_q      <= StIdle;
      addr_q     <= '0;
      write_q    <= 1'b0;
      rem_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mode_q     <= 1'b0;
      wr_tick_q  <= 1'b0;
      rd_tick_q  <= 1'b0;
      dout_q     <= 8'h00;
      rd_pend_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
    end else begin
      mode_q    <= 1'b0;
      wr_tick_q <= 1'b0;
      rd_tick_q <= 1'b0;
      dout_q    <= 8'h00;
      done_q    <= 1'b0;
      // Data reads only; a mode=1 status read's byte is discarded.
      rd_pend_q  <= rd_tick_q & ~mode_q;
      rd_valid_q <= rd_pend_q;
      rd_data_q  <= rd_pend_q ? vdp_din_i : 8'h00;

      unique case (state_q)
        StIdle, StFin: begin
          state_q <= StIdle;
          if (start_i) begin
            addr_q  <= addr_i;
            write_q <= write_i;
            rem_q   <= len_i;
            busy_q  <= 1'b1;
            mode_q  <= 1'b1;
`ifdef VDP_PORT_SYNC_EN
            state_q   <= StSync;
            rd_tick_q <= 1'b1;
`else
            state_q   <= StAddrLo;
            wr_tick_q <= 1'b1;
            dout_q    <= addr_i[7:0];
`endif
          end
        end
        StSync: begin
          state_q <= StGap;
          nxt_q   <= StAddrLo;
        end
        StAddrLo: begin
          state_q <= StGap;
          nxt_q   <= StAddrHi;
        end
        StAddrHi: begin
          state_q <= StGap;
          nxt_q   <= (rem_q == '0) ? StFin : StData;
        end
        StData: begin
          if (wr_tick_q || rd_tick_q) begin
            // rem_q was already decremented when this tick was issued.
            state_q <= StGap;
            nxt_q   <= (rem_q == '0) ? StFin : StData;
          end else if (consume) begin
            wr_tick_q <= 1'b1;
            dout_q    <= wr_data_i;
            rem_q     <= rem_q - LEN_W'(1);
          end
        end
        StGap: begin
          if (gap_done) begin
            state_q <= nxt_q;
            case (nxt_q)
              StAddrLo: begin
                mode_q    <= 1'b1;
                wr_tick_q <= 1'b1;
                dout_q    <= addr_q[7:0];
              end
              StAddrHi: begin
                mode_q    <= 1'b1;
                wr_tick_q <= 1'b1;
                dout_q    <= addr_hi_byte(addr_q, write_q);
              end
              StData: begin
                if (!write_q) begin
                  rd_tick_q <= 1'b1;
                  rem_q     <= rem_q - LEN_W'(1);
                end else if (consume) begin
                  wr_tick_q <= 1'b1;
                  dout_q    <= wr_data_i;
                  rem_q     <= rem_q - LEN_W'(1);
                end
              end
              StFin: begin
                done_q <= 1'b1;
                busy_q <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign vdp_mode_o    = mode_q;
  assign vdp_wr_tick_o = wr_tick_q;
  assign vdp_rd_tick_o = rd_tick_q;
  assign vdp_dout_o    = dout_q;
  assign rd_valid_o    = rd_valid_q;
  assign rd_data_o     = rd_data_q;

endmodule

// File: tb/tb_vdp_port_master.sv
// Directed bench for vdp_port_master with a small VDP port model
// (two-byte address latch, auto-incrementing VRAM).
module tb_vdp_port_master;

  localparam int unsigned TickGap = 2;
  localparam int unsigned LenW    = 14;
`ifdef VDP_PORT_SYNC_EN
  localparam int So = 1;
`else
  localparam int So = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [13:0] addr = '0;
  logic        write = 1'b0;
  logic [13:0] len = '0;
  logic [7:0]  wr_data = 8'h00;
  logic        wr_valid = 1'b0;
  logic        wr_ready_o;
  logic [7:0]  rd_data_o;
  logic        rd_valid_o, busy_o, done_o;
  logic        vdp_mode_o, vdp_wr_tick_o, vdp_rd_tick_o;
  logic [7:0]  vdp_dout_o;
  logic [7:0]  vdp_din = 8'h00;

  vdp_port_master #(
    .TICK_GAP(TickGap),
    .LEN_W   (LenW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .addr_i       (addr),
    .write_i      (write),
    .len_i        (len),
    .wr_data_i    (wr_data),
    .wr_valid_i   (wr_valid),
    .wr_ready_o   (wr_ready_o),
    .rd_data_o    (rd_data_o),
    .rd_valid_o   (rd_valid_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .vdp_mode_o   (vdp_mode_o),
    .vdp_wr_tick_o(vdp_wr_tick_o),
    .vdp_rd_tick_o(vdp_rd_tick_o),
    .vdp_dout_o   (vdp_dout_o),
    .vdp_din_i    (vdp_din)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- VDP port model and logs ----------------
  logic [7:0]  vram [0:16383];
  logic [13:0] m_addr = '0;
  logic [7:0]  m_lo = 8'h00;
  logic        m_phase = 1'b0;
  int          cyc = 0;
  int          t_cyc[$];
  logic        t_mode[$];
  logic        t_rd[$];
  logic [7:0]  t_dout[$];
  logic [7:0]  rd_log[$];
  int          done_cnt = 0;
  int          viol_gap = 0, viol_dout = 0, viol_done = 0;
  int          poke_req = 0, poke_ack = 0;

  initial for (int i = 0; i < 16384; i++) vram[i] = i[7:0];

  always @(negedge clk) begin
    cyc++;
    if (poke_req != poke_ack) begin
      m_lo     = 8'h99;
      m_phase  = 1'b1;
      poke_ack = poke_req;
    end
    if (vdp_wr_tick_o || vdp_rd_tick_o) begin
      t_cyc.push_back(cyc);
      t_mode.push_back(vdp_mode_o);
      t_rd.push_back(vdp_rd_tick_o);
      t_dout.push_back(vdp_dout_o);
    end
    if (vdp_wr_tick_o && vdp_rd_tick_o) viol_gap++;
    if (!vdp_wr_tick_o && !vdp_rd_tick_o && vdp_mode_o) viol_gap++;
    if (!vdp_wr_tick_o && vdp_dout_o != 8'h00) viol_dout++;
    if (vdp_wr_tick_o) begin
      if (vdp_mode_o) begin
        if (!m_phase) begin
          m_lo    = vdp_dout_o;
          m_phase = 1'b1;
        end else begin
          m_addr  = {vdp_dout_o[5:0], m_lo};
          m_phase = 1'b0;
        end
      end else begin
        vram[m_addr] = vdp_dout_o;
        m_addr       = m_addr + 14'd1;
      end
    end
    if (vdp_rd_tick_o) begin
      if (vdp_mode_o) begin
        m_phase = 1'b0;
        vdp_din = 8'h00;
      end else begin
        vdp_din = vram[m_addr];
        m_addr  = m_addr + 14'd1;
      end
    end
    if (rd_valid_o) rd_log.push_back(rd_data_o);
    if (done_o) begin
      done_cnt++;
      if (busy_o) viol_done++;
    end
  end

  // ---------------- write byte source ----------------
  logic [7:0] wbytes [0:7];
  int         wlen = 0, stall_idx = -1, stall_n = 0;
  int         src_gen = 0, src_seen = 0, widx = 0, stall_left = 0, bad_rdy = 0;

  always @(negedge clk) begin
    if (src_gen != src_seen) begin
      src_seen   = src_gen;
      widx       = 0;
      stall_left = stall_n;
    end
    wr_valid = 1'b0;
    if (widx < wlen) begin
      if (widx == stall_idx && stall_left > 0) begin
        stall_left--;
      end else begin
        wr_valid = 1'b1;
        wr_data  = wbytes[widx];
      end
    end
    #1;
    if (wr_ready_o) begin
      if (!wr_valid) bad_rdy++;
      else widx++;
    end
  end

  // ---------------- stimulus helpers ----------------
  int base_t, base_rd, base_done;

  task automatic mark();
    base_t    = t_cyc.size();
    base_rd   = rd_log.size();
    base_done = done_cnt;
  endtask

  task automatic issue(input logic [13:0] a, input logic w, input logic [13:0] l);
    @(negedge clk);
    src_gen++;
    @(negedge clk);
    addr  = a;
    write = w;
    len   = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy_o) check_eq({tag, " timeout"}, 32'd0, 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_tick(input string tag, input int i, input logic m, input logic [7:0] d,
                          input logic rd);
    if (base_t + i >= t_cyc.size()) begin
      check_eq($sformatf("%s tick%0d missing", tag, i), 32'd0, 32'd1);
    end else begin
      check_eq($sformatf("%s tick%0d mode", tag, i), 32'(t_mode[base_t+i]), 32'(m));
      check_eq($sformatf("%s tick%0d dout", tag, i), 32'(t_dout[base_t+i]), 32'(d));
      check_eq($sformatf("%s tick%0d rd", tag, i), 32'(t_rd[base_t+i]), 32'(rd));
    end
  endtask

  task automatic chk_sync(input string tag);
    if (So == 1) chk_tick(tag, 0, 1'b1, 8'h00, 1'b1);
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({wr_ready_o, rd_data_o, rd_valid_o, busy_o, done_o, vdp_mode_o,
                vdp_wr_tick_o, vdp_rd_tick_o, vdp_dout_o});
  endfunction

  // ---------------- tests ----------------
  initial begin
    #2 rst_n = 1'b0;
    #1 check_eq("reset outputs", all_outs(), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: write 0x0000, len 4, always valid
    for (int i = 0; i < 8; i++) wbytes[i] = 8'(i);
    wlen = 4; stall_idx = -1; stall_n = 0;
    mark();
    check_eq("t1 busy before", 32'(busy_o), 32'd0);
    issue(14'h0000, 1'b1, 14'd4);
    check_eq("t1 busy rises", 32'(busy_o), 32'd1);
    wait_idle("t1");
    check_eq("t1 tick count", 32'(t_cyc.size() - base_t), 32'(6 + So));
    chk_sync("t1");
    chk_tick("t1", So + 0, 1'b1, 8'h00, 1'b0);
    chk_tick("t1", So + 1, 1'b1, 8'h40, 1'b0);
    for (int i = 0; i < 4; i++) chk_tick("t1", So + 2 + i, 1'b0, 8'(i), 1'b0);
    for (int i = 1; i < 6 + So; i++) begin
      if (base_t + i < t_cyc.size())
        check_eq($sformatf("t1 spacing%0d", i), 32'(t_cyc[base_t+i] - t_cyc[base_t+i-1]),
                 32'(TickGap + 1));
    end
    check_eq("t1 done", 32'(done_cnt - base_done), 32'd1);

    // T2: read 0x1000, len 3
    wlen = 0;
    mark();
    issue(14'h1000, 1'b0, 14'd3);
    wait_idle("t2");
    check_eq("t2 tick count", 32'(t_cyc.size() - base_t), 32'(5 + So));
    chk_sync("t2");
    chk_tick("t2", So + 0, 1'b1, 8'h00, 1'b0);
    chk_tick("t2", So + 1, 1'b1, 8'h10, 1'b0);
    for (int i = 0; i < 3; i++) chk_tick("t2", So + 2 + i, 1'b0, 8'h00, 1'b1);
    check_eq("t2 rd count", 32'(rd_log.size() - base_rd), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (base_rd + i < rd_log.size())
        check_eq($sformatf("t2 rd_data%0d", i), 32'(rd_log[base_rd+i]), 32'(i));
    end
    check_eq("t2 done", 32'(done_cnt - base_done), 32'd1);

    // T3: write 0x0200, len 4, source stalls before byte 2
    for (int i = 0; i < 4; i++) wbytes[i] = 8'hA0 + 8'(i);
    wlen = 4; stall_idx = 2; stall_n = 8;
    mark();
    issue(14'h0200, 1'b1, 14'd4);
    wait_idle("t3");
    check_eq("t3 tick count", 32'(t_cyc.size() - base_t), 32'(6 + So));
    chk_tick("t3", So + 1, 1'b1, 8'h42, 1'b0);
    for (int i = 0; i < 4; i++) chk_tick("t3", So + 2 + i, 1'b0, 8'hA0 + 8'(i), 1'b0);
    if (base_t + So + 4 < t_cyc.size())
      check_eq("t3 stall stretches gap",
               32'((t_cyc[base_t+So+4] - t_cyc[base_t+So+3]) > int'(TickGap + 1)), 32'd1);
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("t3 vram%0d", i), 32'(vram[14'h200 + 14'(i)]), 32'(8'hA0 + 8'(i)));
    stall_idx = -1; stall_n = 0;

    // T4: len 0 read at 0x3311
    wlen = 0;
    mark();
    issue(14'h3311, 1'b0, 14'd0);
    wait_idle("t4");
    check_eq("t4 tick count", 32'(t_cyc.size() - base_t), 32'(2 + So));
    chk_tick("t4", So + 0, 1'b1, 8'h11, 1'b0);
    chk_tick("t4", So + 1, 1'b1, 8'h33, 1'b0);
    check_eq("t4 done", 32'(done_cnt - base_done), 32'd1);
    check_eq("t4 no rd", 32'(rd_log.size() - base_rd), 32'd0);

    // T5: start while busy ignored, reset mid-DATA abandons command
    for (int i = 0; i < 8; i++) wbytes[i] = 8'h50 + 8'(i);
    wlen = 8;
    mark();
    issue(14'h0100, 1'b1, 14'd8);
    @(negedge clk);
    addr = 14'h2222; write = 1'b0; len = 14'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      int n;
      n = 0;
      while (t_cyc.size() < base_t + So + 4 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (t_cyc.size() < base_t + So + 4) check_eq("t5 data timeout", 32'd0, 32'd1);
    end
    chk_tick("t5", So + 0, 1'b1, 8'h00, 1'b0);
    chk_tick("t5", So + 1, 1'b1, 8'h41, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_eq("t5 outputs in reset", all_outs(), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    begin
      int t_after;
      t_after = t_cyc.size();
      repeat (40) @(negedge clk);
      check_eq("t5 no ticks after reset", 32'(t_cyc.size() - t_after), 32'd0);
    end
    check_eq("t5 no done", 32'(done_cnt - base_done), 32'd0);

    // T6: new command after reset completes normally
    wlen = 0;
    mark();
    issue(14'h1005, 1'b0, 14'd2);
    wait_idle("t6");
    check_eq("t6 rd count", 32'(rd_log.size() - base_rd), 32'd2);
    for (int i = 0; i < 2; i++) begin
      if (base_rd + i < rd_log.size())
        check_eq($sformatf("t6 rd_data%0d", i), 32'(rd_log[base_rd+i]), 32'(5 + i));
    end
    check_eq("t6 done", 32'(done_cnt - base_done), 32'd1);

`ifdef VDP_PORT_SYNC_EN
    // T7: stray address byte in the VDP latch is cleared by the status read
    poke_req++;
    repeat (2) @(negedge clk);
    mark();
    issue(14'h1000, 1'b0, 14'd1);
    wait_idle("t7");
    chk_sync("t7");
    check_eq("t7 rd count", 32'(rd_log.size() - base_rd), 32'd1);
    if (base_rd < rd_log.size()) check_eq("t7 rd_data", 32'(rd_log[base_rd]), 32'h00);
`endif

    check_eq("gap/mode rule", 32'(viol_gap), 32'd0);
    check_eq("dout idle zero", 32'(viol_dout), 32'd0);
    check_eq("ready without valid", 32'(bad_rdy), 32'd0);
    check_eq("busy low at done", 32'(viol_done), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
